// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams in, TX FIFO write port and grant status out.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 5,
    parameter int DW = 8
);
    logic [NREQ-1:0] req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] req_ack;
    logic fifo_full;
    logic fifo_push;
    logic [DW-1:0] fifo_wdata;
    logic busy;
    logic [2:0] grant_id;
    logic abort;
    modport master (
        output req, req_data, req_last, fifo_full,
        input req_ack, fifo_push, fifo_wdata, busy, grant_id, abort
    );
    modport slave (
        input req, req_data, req_last, fifo_full,
        output req_ack, fifo_push, fifo_wdata, busy, grant_id, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter feeding one UART TX FIFO, grant locked until req_last.
// Define UART_ARB_TIMEOUT_EN to abort a packet whose owner stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NREQ = 5,
    parameter int DW = 8,
    parameter int TIMEOUT = 1023
) (
    input logic clk,
    input logic rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic {IDLE, XFER} state_t;
    state_t state_q, state_d;
    logic [2:0] grant_q, grant_d, last_q, last_d, win;
    logic [DW-1:0] wdata_q, wdata_d, data_g;
    logic [IW-1:0] idx;
    logic beat;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic abort;
`endif
    // Scan downward so the final hit is the first requester after last_q.
    always_comb begin
        win = grant_q;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IW'((int'(last_q) + 1 + i) % NREQ);
            if (bus.req[idx]) win = 3'(idx);
        end
    end
    always_comb begin
        data_g = bus.req_data[int'(grant_q)*DW +: DW];
        beat = (state_q == XFER) && bus.req[grant_q] && !bus.fifo_full;
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        wdata_d = beat ? data_g : wdata_q;
        if (state_q == IDLE && |bus.req) begin
            state_d = XFER;
            grant_d = win;
        end
        if (beat && bus.req_last[grant_q]) begin
            state_d = IDLE;
            last_d = grant_q;
        end
`ifdef UART_ARB_TIMEOUT_EN
        abort = 1'b0;
        cnt_d = (state_q == XFER && !beat) ? cnt_q : '0;
        // Only owner silence counts; a full FIFO is not the requester's fault.
        if (state_q == XFER && !bus.req[grant_q] && !bus.fifo_full) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                abort = 1'b1;
                state_d = IDLE;
                last_d = grant_q;
                cnt_d = '0;
            end
        end
`endif
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= 3'(NREQ - 1);
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            wdata_q <= wdata_d;
        end
    end
`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign bus.abort = abort;
`else
    assign bus.abort = 1'b0 && (TIMEOUT > 0);
`endif
    assign bus.fifo_push = beat;
    assign bus.fifo_wdata = beat ? data_g : wdata_q;
    assign bus.req_ack = beat ? (NREQ'(1) << grant_q) : '0;
    assign bus.busy = (state_q == XFER);
    assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized packets against a packet-level model.
module tb_uart_tx_arbiter;
    localparam int NREQ = 5;
    localparam int DW = 8;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1023;
`endif
    typedef struct {
        logic [NREQ-1:0] req, last, ack;
        logic [NREQ*DW-1:0] data;
        logic full, push, busy, abort;
        logic [DW-1:0] wdata;
        logic [2:0] gid;
    } rec_t;

    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
    uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [8:0] src_q [NREQ][$];
    logic [NREQ-1:0] hold = '0;
    logic full = 0;
    rec_t log_q[$];
    int total = 0;
    int bad = 0;

    // One clock cycle: present queue fronts, sample at negedge, pop acked bytes after the edge.
    task automatic cycle();
        logic [NREQ-1:0] r, l;
        logic [NREQ*DW-1:0] d;
        rec_t x;
        r = '0; l = '0; d = '0;
        for (int i = 0; i < NREQ; i++)
            if (src_q[i].size() > 0) begin
                r[i] = !hold[i];
                l[i] = src_q[i][0][8];
                d[i*DW +: DW] = src_q[i][0][7:0];
            end
        bus.req = r; bus.req_last = l; bus.req_data = d; bus.fifo_full = full;
        @(negedge clk);
        x.req = r; x.last = l; x.data = d; x.full = full;
        x.ack = bus.req_ack; x.push = bus.fifo_push; x.busy = bus.busy;
        x.abort = bus.abort; x.wdata = bus.fifo_wdata; x.gid = bus.grant_id;
        log_q.push_back(x);
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) if (x.ack[i]) void'(src_q[i].pop_front());
    endtask

    task automatic do_reset();
        rst = 0;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        hold = '0; full = 0;
        bus.req = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        log_q.delete();
    endtask

    function automatic int rr(input logic [NREQ-1:0] r, input int l);
        for (int k = 1; k <= NREQ; k++) if (r[(l + k) % NREQ]) return (l + k) % NREQ;
        return -1;
    endfunction

    task automatic test_reset();
        src_q[0] = {9'h155};
        repeat (2) cycle();
        foreach (log_q[k]) begin
            total++; if (log_q[k].push !== 1'b0) begin bad++; $display("FAIL reset_push k=%0d got=%b exp=0", k, log_q[k].push); end
            total++; if (log_q[k].ack !== '0) begin bad++; $display("FAIL reset_ack k=%0d got=%b exp=0", k, log_q[k].ack); end
            total++; if (log_q[k].busy !== 1'b0) begin bad++; $display("FAIL reset_busy k=%0d got=%b exp=0", k, log_q[k].busy); end
            total++; if (log_q[k].gid !== 3'd0) begin bad++; $display("FAIL reset_gid k=%0d got=%0d exp=0", k, log_q[k].gid); end
            total++; if (log_q[k].wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata k=%0d got=%h exp=00", k, log_q[k].wdata); end
            total++; if (log_q[k].abort !== 1'b0) begin bad++; $display("FAIL reset_abort k=%0d got=%b exp=0", k, log_q[k].abort); end
        end
    endtask

    task automatic test_single();
        logic [4:0] ep = 5'b01110;
        logic [7:0] ew [5] = '{8'h00, 8'h32, 8'h33, 8'h0A, 8'h0A};
        do_reset();
        src_q[0] = {9'h032, 9'h033, 9'h10A};
        repeat (5) cycle();
        for (int k = 0; k < 5; k++) begin
            total++; if (log_q[k].push !== ep[k]) begin bad++; $display("FAIL single_push k=%0d got=%b exp=%b", k, log_q[k].push, ep[k]); end
            total++; if (log_q[k].busy !== ep[k]) begin bad++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, log_q[k].busy, ep[k]); end
            total++; if (log_q[k].ack !== (ep[k] ? 5'b00001 : 5'b0)) begin bad++; $display("FAIL single_ack k=%0d got=%b", k, log_q[k].ack); end
            total++; if (log_q[k].wdata !== ew[k]) begin bad++; $display("FAIL single_wdata k=%0d got=%h exp=%h", k, log_q[k].wdata, ew[k]); end
        end
    endtask

    task automatic test_round_robin();
        int order [4] = '{1, 3, 4, 1};
        logic [7:0] ew [12] = '{8'h00, 8'h11, 8'h12, 8'h00, 8'h31, 8'h32, 8'h00, 8'h41, 8'h42, 8'h00, 8'h13, 8'h14};
        do_reset();
        src_q[1] = {9'h011, 9'h112, 9'h013, 9'h114};
        src_q[3] = {9'h031, 9'h132};
        src_q[4] = {9'h041, 9'h142};
        repeat (12) cycle();
        for (int k = 0; k < 12; k++) begin
            logic b;
            b = (k % 3) != 0;
            total++; if (log_q[k].push !== b) begin bad++; $display("FAIL rr_push k=%0d got=%b exp=%b", k, log_q[k].push, b); end
            total++; if (log_q[k].busy !== b) begin bad++; $display("FAIL rr_busy k=%0d got=%b exp=%b", k, log_q[k].busy, b); end
            if (b) begin
                total++; if (log_q[k].gid !== 3'(order[k/3])) begin bad++; $display("FAIL rr_gid k=%0d got=%0d exp=%0d", k, log_q[k].gid, order[k/3]); end
                total++; if (log_q[k].wdata !== ew[k]) begin bad++; $display("FAIL rr_wdata k=%0d got=%h exp=%h", k, log_q[k].wdata, ew[k]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] ep = 10'b1100000110;
        logic [7:0] ew [10] = '{8'h00, 8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3};
        do_reset();
        src_q[2] = {9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3};
        for (int k = 0; k < 10; k++) begin
            full = (k >= 3 && k <= 7);
            cycle();
        end
        full = 0;
        for (int k = 0; k < 10; k++) begin
            total++; if (log_q[k].push !== ep[k]) begin bad++; $display("FAIL bp_push k=%0d got=%b exp=%b", k, log_q[k].push, ep[k]); end
            total++; if (log_q[k].ack !== (ep[k] ? 5'b00100 : 5'b0)) begin bad++; $display("FAIL bp_ack k=%0d got=%b", k, log_q[k].ack); end
            total++; if (log_q[k].wdata !== ew[k]) begin bad++; $display("FAIL bp_wdata k=%0d got=%h exp=%h", k, log_q[k].wdata, ew[k]); end
            total++; if (log_q[k].busy !== (k >= 1)) begin bad++; $display("FAIL bp_busy k=%0d got=%b", k, log_q[k].busy); end
        end
        total++; if (src_q[2].size() != 0) begin bad++; $display("FAIL bp_left got=%0d exp=0", src_q[2].size()); end
    endtask

    task automatic test_lock();
        logic [8:0] ep = 9'b101100010;
        logic [8:0] eb = 9'b101111110;
        logic [7:0] ew [9] = '{8'h00, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB1, 8'hB2, 8'hB2, 8'hC0};
        do_reset();
        src_q[0] = {9'h0B0, 9'h0B1, 9'h1B2};
        src_q[1] = {9'h1C0};
        for (int k = 0; k < 9; k++) begin
            hold = (k < 2) ? 5'b00010 : (k <= 4) ? 5'b00001 : 5'b00000;
            cycle();
        end
        hold = '0;
        for (int k = 0; k < 9; k++) begin
            total++; if (log_q[k].push !== ep[k]) begin bad++; $display("FAIL lock_push k=%0d got=%b exp=%b", k, log_q[k].push, ep[k]); end
            total++; if (log_q[k].busy !== eb[k]) begin bad++; $display("FAIL lock_busy k=%0d got=%b exp=%b", k, log_q[k].busy, eb[k]); end
            total++; if (log_q[k].wdata !== ew[k]) begin bad++; $display("FAIL lock_wdata k=%0d got=%h exp=%h", k, log_q[k].wdata, ew[k]); end
            if (eb[k]) begin
                total++; if (log_q[k].gid !== (k == 8 ? 3'd1 : 3'd0)) begin bad++; $display("FAIL lock_gid k=%0d got=%0d", k, log_q[k].gid); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        src_q[4] = {9'h0D0, 9'h0D1, 9'h1D2};
        repeat (2) cycle();
        bus.req = 5'b10000; bus.req_last = '0; bus.req_data = {8'hD1, 32'h0};
        @(negedge clk);
        total++; if (bus.fifo_push !== 1'b1) begin bad++; $display("FAIL rmid_pre_push got=%b exp=1", bus.fifo_push); end
        total++; if (bus.fifo_wdata !== 8'hD1) begin bad++; $display("FAIL rmid_pre_wdata got=%h exp=d1", bus.fifo_wdata); end
        rst = 0;
        #1;
        total++; if (bus.fifo_push !== 1'b0) begin bad++; $display("FAIL rmid_push got=%b exp=0", bus.fifo_push); end
        total++; if (bus.req_ack !== 5'b0) begin bad++; $display("FAIL rmid_ack got=%b exp=0", bus.req_ack); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.fifo_wdata !== 8'h00) begin bad++; $display("FAIL rmid_wdata got=%h exp=00", bus.fifo_wdata); end
        @(posedge clk); #1;
        total++; if (bus.fifo_push !== 1'b0) begin bad++; $display("FAIL rmid_hold_push got=%b exp=0", bus.fifo_push); end
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        src_q[0] = {9'h1E0};
        src_q[4] = {9'h1F0};
        rst = 1;
        log_q.delete();
        repeat (3) cycle();
        total++; if (log_q[0].push !== 1'b0) begin bad++; $display("FAIL rmid_bubble got=%b exp=0", log_q[0].push); end
        total++; if (log_q[1].gid !== 3'd0) begin bad++; $display("FAIL rmid_winner got=%0d exp=0", log_q[1].gid); end
        total++; if (log_q[1].wdata !== 8'hE0 || log_q[1].push !== 1'b1) begin bad++; $display("FAIL rmid_first got=%h/%b exp=e0/1", log_q[1].wdata, log_q[1].push); end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        src_q[2] = {9'h020, 9'h021, 9'h022, 9'h123};
        src_q[3] = {9'h130};
        for (int k = 0; k < 13; k++) begin
            hold = (k >= 3) ? 5'b00100 : 5'b00000;
            cycle();
        end
        hold = '0;
        for (int k = 0; k < 13; k++) begin
            logic eb;
            eb = (k >= 1 && k <= 10) || k == 12;
            total++; if (log_q[k].abort !== (k == 10)) begin bad++; $display("FAIL tmo_abort k=%0d got=%b", k, log_q[k].abort); end
            total++; if (log_q[k].busy !== eb) begin bad++; $display("FAIL tmo_busy k=%0d got=%b exp=%b", k, log_q[k].busy, eb); end
        end
        total++; if (log_q[12].push !== 1'b1 || log_q[12].gid !== 3'd3 || log_q[12].wdata !== 8'h30) begin
            bad++; $display("FAIL tmo_next got=%b/%0d/%h exp=1/3/30", log_q[12].push, log_q[12].gid, log_q[12].wdata);
        end
    endtask
`endif

    task automatic test_random();
        int mg = 0, mlast = NREQ - 1, cyc = 0, left = 1;
        logic mbusy = 0, eb;
        rec_t x;
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int p = $urandom_range(2, 5); p > 0; p--)
                for (int n = $urandom_range(1, 4); n > 0; n--)
                    src_q[i].push_back({n == 1, 8'($urandom)});
        while ((cyc < 400 || left != 0) && cyc < 1200) begin
`ifdef UART_ARB_TIMEOUT_EN
            hold = '0;
`else
            for (int i = 0; i < NREQ; i++) hold[i] = (cyc < 400) && ($urandom_range(0, 4) == 0);
`endif
            full = (cyc < 400) && ($urandom_range(0, 3) == 0);
            cycle();
            x = log_q[$];
            eb = mbusy && x.req[mg] && !x.full;
            total++; if (x.busy !== mbusy) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, x.busy, mbusy); end
            total++; if (x.push !== eb) begin bad++; $display("FAIL rand_push cyc=%0d got=%b exp=%b", cyc, x.push, eb); end
            total++; if (x.ack !== (eb ? NREQ'(1) << mg : NREQ'(0))) begin bad++; $display("FAIL rand_ack cyc=%0d got=%b g=%0d", cyc, x.ack, mg); end
            total++; if (x.abort !== 1'b0) begin bad++; $display("FAIL rand_abort cyc=%0d got=%b exp=0", cyc, x.abort); end
            if (mbusy) begin
                total++; if (x.gid !== 3'(mg)) begin bad++; $display("FAIL rand_gid cyc=%0d got=%0d exp=%0d", cyc, x.gid, mg); end
            end
            if (eb) begin
                total++; if (x.wdata !== x.data[mg*DW +: DW]) begin bad++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, x.wdata, x.data[mg*DW +: DW]); end
            end
            if (!mbusy && |x.req) begin
                mbusy = 1;
                mg = rr(x.req, mlast);
            end else if (eb && x.last[mg]) begin
                mbusy = 0;
                mlast = mg;
            end
            left = 0;
            for (int i = 0; i < NREQ; i++) left += src_q[i].size();
            cyc++;
        end
        hold = '0; full = 0;
        total++; if (left != 0) begin bad++; $display("FAIL rand_drain got=%0d bytes left exp=0", left); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
